modn_step_arbiter: RTL and testbench
====================================

// Module: modn_step_arbiter
// PURPOSE
//   Shares one mod-N up/down position counter between two requesters.
//   Each requester asks for a run of L steps in a chosen direction. The block
//   arbitrates round-robin, sequences the granted run one step per cycle, and
//   reports ack, done, position and wrap.
//   It sits between client FSMs and any logic that consumes the shared
//   position, for example a phase or slot selector.
// PARAMETERS
//   N      6  modulus; pos ranges over 0..N-1 (N >= 2)
//   WIDTH  3  pos width; must satisfy 2**WIDTH >= N
//   LEN_W  4  width of each step-count field
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous, active-high reset
//   req_valid  in   2          per-requester request; held until req_ack
//   req_dir    in   2          per-requester direction: 1 = up, 0 = down
//   req_len    in   2*LEN_W    step count; requester i uses [i*LEN_W +: LEN_W]
//   pause      in   1          freezes stepping while high, RUN state only
//   req_ack    out  2          1-cycle pulse: request accepted
//   req_done   out  2          1-cycle pulse: run complete
//   busy       out  1          high in RUN and DONE
//   owner      out  1          index of the current or last granted requester
//   pos        out  WIDTH      shared position, 0..N-1
//   step       out  1          1-cycle pulse: pos changed on the last edge
//   wrap       out  1          1-cycle pulse with step: N-1->0 or 0->N-1
// BEHAVIOUR
//   Reset (rst=1 at an edge; wins over everything, including mid-run):
//     state=IDLE, pos=0, owner=0, last_owner=1; all pulses and busy are 0.
//     No req_done is issued for an aborted run. The latched dir/len are cleared.
//   FSM: IDLE -> RUN -> DONE -> IDLE. A zero-length run goes IDLE -> DONE.
//   IDLE:
//     - If any req_valid, grant g = the valid requester. If both are valid,
//       g = ~last_owner.
//     - Latch dir=req_dir[g], rem=req_len[g], owner=g.
//     - Next state is RUN if rem != 0, otherwise DONE.
//     - req_ack[g]=1 in the first cycle after acceptance (registered).
//     - The requester must drop req_valid from the cycle after req_ack.
//   RUN:
//     - On each edge with pause=0: pos steps once and rem decrements.
//       Go to DONE when rem goes from 1 to 0.
//     - With pause=1: pos and rem hold and no step pulse is produced.
//     - req_valid is ignored outside IDLE; requests are never queued here.
//   DONE:
//     - req_done[owner]=1 for exactly one cycle; last_owner<=owner;
//       next state is IDLE.
//   Step arithmetic:
//     - Up:   pos==N-1 ? 0   : pos+1.
//     - Down: pos==0   ? N-1 : pos-1.
//     - No % operator and no subtraction underflow; pos never leaves 0..N-1.
//   step/wrap are registered alongside pos: high in the cycle pos shows its
//   new value.
//   Latency, with acceptance at cycle t, run length L>0 and no pause:
//     - ack and busy rise at t+1.
//     - pos updates become visible at t+2 .. t+L+1.
//     - req_done at t+L+1.
//     - IDLE at t+L+2; the earliest next accept is at t+L+2.
//   L=0: req_ack and req_done both occur at t+1, with no step pulse.
//   pos persists across runs and owners; only rst returns it to 0.
//   busy is 0 only in IDLE; owner holds its value through IDLE.
// TESTING
//   1 Reset, then req0 up L=3 -> ack0 at t+1; pos 1,2,3 at t+2..t+4;
//     done0 at t+4; no wrap.
//   2 pos=4 (N=6), up L=4 -> pos 5,0,1,2; wrap only on the 5->0 step;
//     step high 4 cycles.
//   3 pos=1, down L=3 -> pos 0,5,4; wrap only on the 0->5 step.
//   4 Both valid in IDLE after reset -> req0 granted; after done0, req1
//     (still held) is granted; then both again -> req0 (alternates).
//   5 L=0 -> ack and done in the same cycle; pos unchanged; busy high
//     1 cycle.
//   6 pause high 2 cycles mid-run -> pos holds, step low, done delayed by
//     2 cycles. Then rst mid-run -> pos=0, IDLE, no done pulse.

Source files
------------

// File: rtl/modn_step_arbiter.sv
// Two-requester round-robin arbiter that sequences runs of up/down steps
// on one shared mod-N position counter.
module modn_step_arbiter #(
  parameter int N     = 6,
  parameter int WIDTH = 3,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [1:0]         req_dir,
  input  logic [2*LEN_W-1:0] req_len,
  input  logic               pause,
  output logic [1:0]         req_ack,
  output logic [1:0]         req_done,
  output logic               busy,
  output logic               owner,
  output logic [WIDTH-1:0]   pos,
  output logic               step,
  output logic               wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] POS_MAX = WIDTH'(N - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pos_q, pos_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic               dir_q, dir_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         done_q, done_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;

  // Per-requester view of the packed length bus.
  logic [LEN_W-1:0]   len_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_len
      assign len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Neighbouring positions computed without modulo or underflow.
  logic [WIDTH-1:0] pos_up, pos_dn;
  assign pos_up = (pos_q == POS_MAX) ? '0 : pos_q + WIDTH'(1);
  assign pos_dn = (pos_q == '0) ? POS_MAX : pos_q - WIDTH'(1);

  logic grant;

  // Next-state, arbitration and stepping; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    dir_d        = dir_q;
    rem_d        = rem_q;
    ack_d        = '0;
    done_d       = '0;
    step_d       = 1'b0;
    wrap_d       = 1'b0;
    grant        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          // When both ask, the one that did not go last wins.
          grant        = (req_valid == 2'b11) ? ~last_owner_q : req_valid[1];
          owner_d      = grant;
          dir_d        = req_dir[grant];
          rem_d        = len_arr[grant];
          ack_d[grant] = 1'b1;
          if (len_arr[grant] == '0) begin
            // Zero-length run: done is registered together with ack.
            state_d       = S_DONE;
            done_d[grant] = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!pause) begin
          pos_d  = dir_q ? pos_up : pos_dn;
          wrap_d = dir_q ? (pos_q == POS_MAX) : (pos_q == '0);
          step_d = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            // Done is raised so it shows in the first DONE cycle.
            state_d         = S_DONE;
            done_d[owner_q] = 1'b1;
          end
        end
      end
      S_DONE: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pos_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      dir_q        <= 1'b0;
      rem_q        <= '0;
      ack_q        <= '0;
      done_q       <= '0;
      step_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      dir_q        <= dir_d;
      rem_q        <= rem_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      step_q       <= step_d;
      wrap_q       <= wrap_d;
    end
  end

  assign req_ack  = ack_q;
  assign req_done = done_q;
  assign busy     = (state_q != S_IDLE);
  assign owner    = owner_q;
  assign pos      = pos_q;
  assign step     = step_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_modn_step_arbiter.sv
// Scoreboard bench: stimulus pushes expected ack/step/done events with
// their cycle numbers; a negedge monitor pops and compares them.
module tb_modn_step_arbiter;

  localparam int N     = 6;
  localparam int WIDTH = 3;
  localparam int LEN_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         req_valid = '0;
  logic [1:0]         req_dir = '0;
  logic [2*LEN_W-1:0] req_len = '0;
  logic               pause = 1'b0;
  logic [1:0]         req_ack;
  logic [1:0]         req_done;
  logic               busy;
  logic               owner;
  logic [WIDTH-1:0]   pos;
  logic               step;
  logic               wrap;

  modn_step_arbiter #(.N(N), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir),
    .req_len(req_len), .pause(pause), .req_ack(req_ack), .req_done(req_done),
    .busy(busy), .owner(owner), .pos(pos), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int idx;
    int pos;
    int wrap;
  } ev_t;

  ev_t ack_exp[$];
  ev_t done_exp[$];
  ev_t step_exp[$];

  int checks = 0;
  int errors = 0;
  int mpos = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: got pulse expected none", name, cyc);
  endtask

  // Push ack, every step and done for one run accepted so ack shows at ac.
  // A pause of plen cycles after step pat delays later events by plen.
  task automatic push_run(input int g, input bit dir, input int len,
                          input int ac, input int pat, input int plen);
    ev_t e;
    int  d;
    e = '{ac, g, 0, 0};
    ack_exp.push_back(e);
    for (int i = 1; i <= len; i++) begin
      d = (plen > 0 && i > pat) ? plen : 0;
      if (dir) begin
        e = '{ac + i + d, g, (mpos == N-1) ? 0 : mpos + 1, (mpos == N-1) ? 1 : 0};
      end else begin
        e = '{ac + i + d, g, (mpos == 0) ? N-1 : mpos - 1, (mpos == 0) ? 1 : 0};
      end
      mpos = e.pos;
      step_exp.push_back(e);
    end
    d = (plen > 0 && pat < len) ? plen : 0;
    e = '{ac + len + d, g, 0, 0};
    done_exp.push_back(e);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one run from IDLE; caller sits #1 after a posedge.
  task automatic run(input int g, input bit dir, input int len,
                     input int pat, input int plen);
    int c;
    int endc;
    c = cyc;
    req_valid[g] = 1'b1;
    req_dir[g]   = dir;
    req_len[g*LEN_W +: LEN_W] = LEN_W'(len);
    push_run(g, dir, len, c + 1, pat, plen);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    endc = c + 2 + len + ((plen > 0 && pat < len) ? plen : 0);
    while (cyc < endc) begin
      pause = (plen > 0) && (cyc >= c + 1 + pat) && (cyc < c + 1 + pat + plen);
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
    chk("idle_busy", int'(busy), 0);
    $display("run req%0d dir=%0d len=%0d pause=%0d done, pos model=%0d dut=%0d",
             g, dir, len, plen, mpos, pos);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    mpos = 0;
    chk("rst_pos", int'(pos), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_ack", int'(req_ack), 0);
    chk("rst_done", int'(req_done), 0);
    chk("rst_step", int'(step), 0);
    rst = 1'b0;
    $display("reset applied");
  endtask

  // Monitor: pop an expectation for every pulse the DUT presents.
  always @(negedge clk) begin
    ev_t e;
    for (int i = 0; i < 2; i++) begin
      if (req_ack[i] === 1'b1) begin
        if (ack_exp.size() == 0) unexpected("ack_unexpected");
        else begin
          e = ack_exp.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_idx", i, e.idx);
          chk("ack_busy", int'(busy), 1);
          chk("ack_owner", int'(owner), e.idx);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (req_done[i] === 1'b1) begin
        if (done_exp.size() == 0) unexpected("done_unexpected");
        else begin
          e = done_exp.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("done_idx", i, e.idx);
          chk("done_owner", int'(owner), e.idx);
        end
      end
    end
    if (step === 1'b1) begin
      if (step_exp.size() == 0) unexpected("step_unexpected");
      else begin
        e = step_exp.pop_front();
        chk("step_cycle", cyc, e.cyc);
        chk("step_pos", int'(pos), e.pos);
        chk("step_wrap", int'(wrap), e.wrap);
      end
    end else if (wrap === 1'b1) begin
      unexpected("wrap_without_step");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    do_reset();

    // Basic run, then wrap upward and downward.
    run(0, 1'b1, 3, 99, 0);         // pos 1,2,3
    run(1, 1'b1, 1, 99, 0);         // pos 4
    run(0, 1'b1, 4, 99, 0);         // pos 5,0,1,2 (wrap on 5->0)
    run(1, 1'b0, 1, 99, 0);         // pos 1
    run(0, 1'b0, 3, 99, 0);         // pos 0,5,4 (wrap on 0->5)

    // Round-robin: both valid after reset -> 0, then held req1, then 0 again.
    do_reset();
    c = cyc;
    req_valid = 2'b11;
    req_dir   = 2'b01;
    req_len   = {LEN_W'(1), LEN_W'(2)};
    push_run(0, 1'b1, 2, c + 1, 99, 0);
    push_run(1, 1'b0, 1, c + 5, 99, 0);
    wait_until(c + 1);
    req_valid[0] = 1'b0;
    wait_until(c + 5);
    req_valid[1] = 1'b0;
    wait_until(c + 7);
    c = cyc;
    req_valid = 2'b11;
    req_dir   = 2'b11;
    req_len   = {LEN_W'(1), LEN_W'(1)};
    push_run(0, 1'b1, 1, c + 1, 99, 0);
    wait_until(c + 1);
    req_valid = 2'b00;
    wait_until(c + 4);
    chk("rr_pos", int'(pos), mpos);
    $display("round-robin sequence finished, pos=%0d", pos);

    // Zero-length run: ack and done together, no step, busy one cycle.
    run(1, 1'b1, 0, 99, 0);
    chk("l0_pos", int'(pos), mpos);

    // Pause for two cycles after the second step.
    run(0, 1'b1, 4, 2, 2);

    // Reset in the middle of a run: two steps seen, then no done.
    c = cyc;
    req_valid[0] = 1'b1;
    req_dir[0]   = 1'b1;
    req_len[0 +: LEN_W] = LEN_W'(5);
    begin
      ev_t e;
      e = '{c + 1, 0, 0, 0};
      ack_exp.push_back(e);
      for (int i = 1; i <= 2; i++) begin
        e = '{c + 1 + i, 0, (mpos == N-1) ? 0 : mpos + 1, (mpos == N-1) ? 1 : 0};
        mpos = e.pos;
        step_exp.push_back(e);
      end
    end
    wait_until(c + 1);
    req_valid[0] = 1'b0;
    wait_until(c + 3);
    do_reset();
    wait_until(cyc + 8);
    chk("abort_busy", int'(busy), 0);
    chk("abort_pos", int'(pos), 0);

    // A run after the abort starts from position 0.
    run(1, 1'b0, 2, 99, 0);         // pos 5,4

    wait_until(cyc + 3);
    chk("ack_left", ack_exp.size(), 0);
    chk("done_left", done_exp.size(), 0);
    chk("step_left", step_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
